// File: rtl/mips_pkg.sv
// Shared MIPS encodings and hazard-controller types.
// Opcodes and functs are the subset the hazard logic has to recognise.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BUBBLE = 6'b111111;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} md_state_e;
endpackage

// File: rtl/md_tracker.sv
// Tracks an in-flight multiply/divide; md_busy stays high for MD_CYCLES-1
// cycles after the issuing edge.
module md_tracker
  import mips_pkg::*;
#(
  parameter int MD_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  output logic md_busy
);
  md_state_e  state_q, state_d;
  logic [4:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // issue is already masked by stall, so a new mult/div can never arrive in MD_BUSY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: if (issue) begin
        state_d = MD_BUSY;
        cnt_d   = 5'(MD_CYCLES - 1);
      end
      MD_BUSY: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    md_busy = (state_q == MD_BUSY);
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / HI-LO stall and branch/jump flush control beside the ID stage.
// All outputs are combinational on the ID fields; only the md unit has state.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] id_opcode,
  input  logic [5:0] id_func,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       branch_taken,
  input  logic       jump,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       md_busy
);
  logic is_rtype, is_md, is_hilo, uses_rs, uses_rt;
  logic load_use, md_stall, stall, issue;

  assign is_rtype = (id_opcode == OP_RTYPE);
  assign is_md    = is_rtype && (id_func == F_MULT || id_func == F_MULTU ||
                                 id_func == F_DIV  || id_func == F_DIVU);
  assign is_hilo  = is_rtype && (id_func == F_MFHI || id_func == F_MFLO);
  assign uses_rs  = !(id_opcode == OP_J || id_opcode == OP_JAL || id_opcode == OP_BUBBLE);
  assign uses_rt  = is_rtype || id_opcode == OP_BEQ || id_opcode == OP_BNE ||
                    id_opcode == OP_SW;

  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((uses_rs && ex_rt == id_rs) || (uses_rt && ex_rt == id_rt));
  assign md_stall = md_busy && (is_hilo || is_md);
  assign stall    = load_use || md_stall;
  assign issue    = is_md && !stall;

  md_tracker #(.MD_CYCLES(MD_CYCLES)) u_md (
    .clk     (clk),
    .rst_n   (rst_n),
    .issue   (issue),
    .md_busy (md_busy)
  );

  // A stalled branch stays in ID and is re-evaluated, so stall wins over flush
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (branch_taken || jump) begin
      ifid_flush  = 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with MD_CYCLES=4: expected output vectors
// {pc_write, ifid_write, ifid_flush, idex_bubble, md_busy} are queued per cycle.
module tb_hazard_ctrl;
  localparam int MDC = 4;
  localparam logic [5:0] RT = 6'b000000, J = 6'b000010, BEQ = 6'b000100,
                         LW = 6'b100011, SW = 6'b101011, BUB = 6'b111111;
  localparam logic [5:0] ADD = 6'b100000, MULT = 6'b011000, DIV = 6'b011010,
                         MFHI = 6'b010000, MFLO = 6'b010010;
  localparam logic [4:0] NORM = 5'b11000, NORMB = 5'b11001,
                         FLSH = 5'b11100, FLSHB = 5'b11101,
                         STL = 5'b00010, STLB = 5'b00011;

  logic clk, rst_n;
  logic [5:0] id_opcode, id_func;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic ex_memread, branch_taken, jump;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, md_busy;

  typedef struct {string tag; logic [4:0] v;} exp_t;
  exp_t exp_q[$];
  logic [4:0] obs_q[$];
  int errors = 0, checks = 0;

  hazard_ctrl #(.MD_CYCLES(MDC)) dut (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_func(id_func),
    .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .jump(jump), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {pc_write, ifid_write, ifid_flush, idex_bubble, md_busy};
  endfunction

  // One pipeline cycle: drive after the edge, queue expectation, sample at negedge.
  task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                     input logic [4:0] rt, input logic mr, input logic [4:0] er,
                     input logic br, input logic jm, input logic [4:0] e, input string tag);
    exp_t x;
    @(posedge clk); #1;
    id_opcode = op; id_func = fn; id_rs = rs; id_rt = rt;
    ex_memread = mr; ex_rt = er; branch_taken = br; jump = jm;
    x.tag = tag; x.v = e;
    exp_q.push_back(x);
    @(negedge clk);
    obs_q.push_back(outs());
  endtask

  task automatic test_reset();
    exp_t e; logic [4:0] o;
    rst_n = 1'b0;
    id_opcode = BUB; id_func = 6'd0; id_rs = 5'd0; id_rt = 5'd0;
    ex_memread = 1'b0; ex_rt = 5'd0; branch_taken = 1'b0; jump = 1'b0;
    #2;
    checks++;
    if (outs() !== NORM) begin
      errors++; $display("FAIL reset_init: got %b want %b", outs(), NORM);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(RT, MULT, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, NORM, "rst_mult_issue");
    cyc(RT, MFHI, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, STLB, "rst_mfhi_stall");
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== NORM) begin
      errors++; $display("FAIL reset_midrun: got %b want %b", outs(), NORM);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(RT, MFHI, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, NORM, "rst_after_mfhi");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    end
  endtask

  task automatic test_load_use();
    exp_t e; logic [4:0] o;
    cyc(RT, ADD, 5'd8, 5'd9, 1'b1, 5'd8, 1'b0, 1'b0, STL,  "lu_rs_match");
    cyc(RT, ADD, 5'd8, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, NORM, "lu_release");
    cyc(RT, ADD, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, NORM, "lu_rt_zero");
    cyc(SW, 6'd0, 5'd1, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, STL, "lu_sw_rt");
    cyc(LW, 6'd0, 5'd1, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, NORM, "lu_lw_rt_unused");
    cyc(RT, ADD, 5'd3, 5'd4, 1'b1, 5'd8, 1'b0, 1'b0, NORM, "lu_no_match");
    cyc(BUB, ADD, 5'd8, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, NORM, "lu_bubble");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    end
  endtask

  task automatic test_branch_flush();
    exp_t e; logic [4:0] o;
    cyc(BEQ, 6'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, FLSH, "br_flush");
    cyc(BEQ, 6'd0, 5'd1, 5'd2, 1'b1, 5'd1, 1'b1, 1'b0, STL,  "br_lu_stall");
    cyc(BEQ, 6'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, NORM, "br_not_taken");
    cyc(J,   6'd0, 5'd5, 5'd6, 1'b1, 5'd5, 1'b0, 1'b1, FLSH, "j_no_rs_use");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    end
  endtask

  task automatic test_multiply();
    exp_t e; logic [4:0] o;
    cyc(RT, MULT, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, NORM, "mul_issue");
    for (int i = 0; i < MDC - 1; i++)
      cyc(RT, MFHI, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, STLB, $sformatf("mfhi_stall%0d", i));
    cyc(RT, MFHI, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, NORM, "mfhi_release");
    cyc(BUB, MULT, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, NORM, "bubble_no_issue");
    cyc(RT, MFLO, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, NORM, "mflo_idle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [4:0] o;
    cyc(RT, MULT, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, NORM, "b2b_first");
    // first stalled cycle also carries a load-use on rs: one combined stall
    cyc(RT, DIV, 5'd3, 5'd4, 1'b1, 5'd3, 1'b0, 1'b0, STLB, "b2b_stall_lu");
    cyc(RT, DIV, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, STLB, "b2b_stall1");
    cyc(RT, DIV, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, STLB, "b2b_stall2");
    cyc(RT, DIV, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, NORM, "b2b_second_issue");
    for (int i = 0; i < MDC - 1; i++)
      cyc(RT, ADD, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, NORMB, $sformatf("b2b_busy%0d", i));
    cyc(RT, ADD, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, NORM, "b2b_idle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    end
  endtask

  task automatic test_jump_busy();
    exp_t e; logic [4:0] o;
    cyc(RT, MULT, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, NORM, "jb_issue");
    cyc(J,   6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, FLSHB, "jb_jump");
    cyc(RT,  ADD,  5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, NORMB, "jb_add");
    cyc(BEQ, 6'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, FLSHB, "jb_beq");
    cyc(RT,  ADD,  5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, NORM,  "jb_done");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_flush();
    test_multiply();
    test_back_to_back();
    test_jump_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
